pipeline_control: RTL and testbench

//  Central sequencer for the 5-stage LC-3b pipeline: drives the load enables of the PC and of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB stage buffers, and tracks a valid bit per stage.

---
 rtl/pipeline_control.sv | 150 +++++++++++++++
 tb/tb_pipeline_control.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Sequencer for the 5-stage LC-3b pipeline: stage load enables, per-stage valid bits,
// D-mem access FSM for LDI/STI, hazard resolution and saturating perf counters.
module pipeline_control #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_resp,
    input  logic                 dmem_resp,
    input  logic [2:0]           id_src1,
    input  logic [2:0]           id_src2,
    input  logic                 id_src1_used,
    input  logic                 id_src2_used,
    input  logic                 ex_is_load,
    input  logic [2:0]           ex_dest,
    input  logic                 mem_req,
    input  logic                 mem_indirect,
    input  logic                 br_taken,
    output logic                 load_pc,
    output logic                 pc_sel_br,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 valid_id,
    output logic                 valid_ex,
    output logic                 valid_mem,
    output logic                 valid_wb,
    output logic                 imem_read,
    output logic                 dmem_req,
    output logic                 dmem_phase,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic D_IDLE = 1'b0;
    localparam logic D_IND  = 1'b1;

    logic state_q, state_d;
    logic valid_id_d, valid_ex_d, valid_mem_d, valid_wb_d;
    logic mem_active, mem_done, dmem_req_raw;
    logic dmem_stall, imem_stall, load_use, redirect, stall_any;

    assign mem_active = valid_mem & mem_req;
    assign imem_stall = ~imem_resp;
    assign imem_read  = ~reset;

    always_comb begin
        state_d      = state_q;
        dmem_req_raw = 1'b0;
        dmem_phase   = 1'b0;
        mem_done     = 1'b1;
        case (state_q)
            D_IDLE: begin
                if (mem_active) begin
                    dmem_req_raw = 1'b1;
                    mem_done     = 1'b0;
                    if (dmem_resp) begin
                        if (mem_indirect) state_d = D_IND;
                        else              mem_done = 1'b1;
                    end
                end
            end
            default: begin
                dmem_req_raw = 1'b1;
                dmem_phase   = 1'b1;
                mem_done     = 1'b0;
                if (dmem_resp) begin
                    state_d  = D_IDLE;
                    mem_done = 1'b1;
                end
            end
        endcase
    end

    assign dmem_req   = dmem_req_raw & ~reset;
    assign dmem_stall = ~mem_done;
    assign load_use   = valid_ex & ex_is_load & valid_id &
                        ((id_src1_used & (id_src1 == ex_dest)) |
                         (id_src2_used & (id_src2 == ex_dest)));
    assign redirect   = valid_mem & br_taken & mem_done;
    // A redirect cycle is never counted as a stall, even with imem_stall set.
    assign stall_any  = ~redirect & (dmem_stall | load_use | imem_stall);

    always_comb begin
        load_pc     = 1'b1;
        pc_sel_br   = 1'b0;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        valid_id_d  = 1'b1;
        valid_ex_d  = valid_id;
        valid_mem_d = valid_ex;
        valid_wb_d  = valid_mem;
        if (dmem_stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            valid_id_d  = valid_id;
            valid_ex_d  = valid_ex;
            valid_mem_d = valid_mem;
            valid_wb_d  = 1'b0;
        end else if (redirect) begin
            pc_sel_br   = 1'b1;
            valid_id_d  = 1'b0;
            valid_ex_d  = 1'b0;
            valid_mem_d = 1'b0;
            valid_wb_d  = 1'b1;
        end else if (load_use) begin
            load_pc    = 1'b0;
            load_if_id = 1'b0;
            valid_id_d = valid_id;
            valid_ex_d = 1'b0;
        end else if (imem_stall) begin
            load_pc    = 1'b0;
            valid_id_d = 1'b0;
        end
        if (reset) begin
            load_pc     = 1'b0;
            pc_sel_br   = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= D_IDLE;
            valid_id    <= 1'b0;
            valid_ex    <= 1'b0;
            valid_mem   <= 1'b0;
            valid_wb    <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_q   <= state_d;
            valid_id  <= valid_id_d;
            valid_ex  <= valid_ex_d;
            valid_mem <= valid_mem_d;
            valid_wb  <= valid_wb_d;
            if (stall_any && stall_count != {CNT_WIDTH{1'b1}}) stall_count <= stall_count + 1'b1;
            if (redirect && flush_count != {CNT_WIDTH{1'b1}}) flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control (CNT_WIDTH=4 so saturation is reachable).
module tb_pipeline_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_resp, dmem_resp;
    logic [2:0] id_src1, id_src2, ex_dest;
    logic       id_src1_used, id_src2_used, ex_is_load;
    logic       mem_req, mem_indirect, br_taken;
    logic       load_pc, pc_sel_br, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic       valid_id, valid_ex, valid_mem, valid_wb;
    logic       imem_read, dmem_req, dmem_phase;
    logic [3:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    pipeline_control #(.CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(id_src1_used),
        .id_src2_used(id_src2_used), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .mem_req(mem_req), .mem_indirect(mem_indirect), .br_taken(br_taken),
        .load_pc(load_pc), .pc_sel_br(pc_sel_br), .load_if_id(load_if_id),
        .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .imem_read(imem_read), .dmem_req(dmem_req), .dmem_phase(dmem_phase),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] loads();
        return 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb});
    endfunction

    function automatic logic [31:0] valids();
        return 32'({valid_id, valid_ex, valid_mem, valid_wb});
    endfunction

    initial begin
        reset = 1'b1; imem_resp = 1'b1; dmem_resp = 1'b0;
        id_src1 = 3'd0; id_src2 = 3'd0; id_src1_used = 1'b0; id_src2_used = 1'b0;
        ex_is_load = 1'b0; ex_dest = 3'd0; mem_req = 1'b0; mem_indirect = 1'b0;
        br_taken = 1'b0;

        // 1: reset and pipeline fill
        for (int i = 0; i < 3; i++) step();
        check("rst_loads", loads(), 32'h00);
        check("rst_imem_read", 32'(imem_read), 32'd0);
        check("rst_valids", valids(), 32'h0);
        check("rst_stall_cnt", 32'(stall_count), 32'd0);
        reset = 1'b0;
        #1;
        check("fill_loads", loads(), 32'h1f);
        check("fill_imem_read", 32'(imem_read), 32'd1);
        step();
        check("fill_c1_valids", valids(), 32'h8);
        for (int i = 0; i < 3; i++) step();
        check("fill_c4_valids", valids(), 32'hf);
        check("fill_loads2", loads(), 32'h1f);
        check("fill_stall_cnt", 32'(stall_count), 32'd0);

        // 2: load-use bubble (LDR R1 in EX, ADD R2,R1,R3 in ID)
        ex_is_load = 1'b1; ex_dest = 3'd1;
        id_src1 = 3'd1; id_src1_used = 1'b1; id_src2 = 3'd3; id_src2_used = 1'b1;
        #1;
        check("lu_loads", loads(), 32'h07);
        step();
        check("lu_valids", valids(), 32'hb);
        check("lu_stall_cnt", 32'(stall_count), 32'd1);
        ex_is_load = 1'b0; id_src1_used = 1'b0; id_src2_used = 1'b0;
        #1;
        check("lu_after_loads", loads(), 32'h1f);
        for (int i = 0; i < 3; i++) step();
        check("lu_refill_valids", valids(), 32'hf);

        // 3: LDI in MEM, each phase answered on its third cycle
        mem_req = 1'b1; mem_indirect = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmem_resp = (i == 2 || i == 5);
            #1;
            check($sformatf("ldi_req_%0d", i), 32'(dmem_req), 32'd1);
            check($sformatf("ldi_phase_%0d", i), 32'(dmem_phase), (i < 3) ? 32'd0 : 32'd1);
            if (i < 5) check($sformatf("ldi_loads_%0d", i), loads(), 32'h01);
            else       check("ldi_done_loads", loads(), 32'h1f);
            step();
            if (i < 5) check($sformatf("ldi_wb_%0d", i), 32'(valid_wb), 32'd0);
        end
        mem_req = 1'b0; mem_indirect = 1'b0; dmem_resp = 1'b0;
        #1;
        check("ldi_wb_after", 32'(valid_wb), 32'd1);
        check("ldi_req_after", 32'(dmem_req), 32'd0);
        check("ldi_stall_cnt", 32'(stall_count), 32'd6);

        // 4: taken branch in MEM while I-mem is stalled
        br_taken = 1'b1; imem_resp = 1'b0;
        #1;
        check("br_loads", loads(), 32'h1f);
        check("br_pc_sel", 32'(pc_sel_br), 32'd1);
        step();
        br_taken = 1'b0; imem_resp = 1'b1;
        check("br_valids", valids(), 32'h1);
        check("br_flush_cnt", 32'(flush_count), 32'd1);
        check("br_stall_cnt", 32'(stall_count), 32'd6);

        // 5: reset while the FSM is in its second indirect phase
        for (int i = 0; i < 3; i++) step();
        check("rind_valids", valids(), 32'he);
        mem_req = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b1;
        step();
        dmem_resp = 1'b0;
        #1;
        check("rind_phase1", 32'(dmem_phase), 32'd1);
        reset = 1'b1;
        #1;
        check("rind_req_rst", 32'(dmem_req), 32'd0);
        check("rind_loads_rst", loads(), 32'h00);
        step();
        reset = 1'b0;
        #1;
        check("rind_req_after", 32'(dmem_req), 32'd0);
        check("rind_phase_after", 32'(dmem_phase), 32'd0);
        check("rind_valids", valids(), 32'h0);
        check("rind_cnts", 32'({stall_count, flush_count}), 32'h00);
        mem_req = 1'b0; mem_indirect = 1'b0;

        // 6: sustained I-mem stall saturates the stall counter
        imem_resp = 1'b0;
        #1;
        check("istall_loads", loads(), 32'h0f);
        for (int i = 0; i < 15; i++) step();
        check("istall_cnt15", 32'(stall_count), 32'd15);
        for (int i = 0; i < 5; i++) step();
        check("istall_sat", 32'(stall_count), 32'd15);
        check("istall_valid_id", 32'(valid_id), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
